// File: rtl/cone_bist_pkg.sv
// Shared types and constants for the cone BIST controller: FSM states,
// LFSR tap mask, MISR polynomial and the LFSR step function.
package cone_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // x^24+x^23+x^22+x^17+1 as a mask over lfsr[23:0]
  localparam logic [23:0] LFSR_TAPS = 24'hE10000;
  localparam int          SIG_W_DEF = 16;
  localparam logic [15:0] MISR_POLY = 16'h1021;

  function automatic logic [23:0] lfsr_next(input logic [23:0] s);
    return {s[22:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/cone_bist_misr.sv
// Serial-input signature register: compacts one response bit per enabled
// cycle into a SIG_W-bit Galois-style MISR.
module cone_bist_misr
  import cone_bist_pkg::*;
#(
  parameter int               SIG_W = SIG_W_DEF,
  parameter logic [SIG_W-1:0] POLY  = SIG_W'(MISR_POLY)
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             en,
  input  logic             clr,
  input  logic             resp_in,
  output logic [SIG_W-1:0] sig
);

  logic fb;

  assign fb = sig[SIG_W-1] ^ resp_in;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      sig <= '0;
    end else if (clr) begin
      sig <= '0;
    end else if (en) begin
      sig <= {sig[SIG_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
  end

endmodule

// File: rtl/cone_bist_ctrl.sv
// BIST controller around a combinational cone: LFSR stimulus on vec_out,
// MISR compaction of resp_in, and a golden-signature compare after PATTERNS.
module cone_bist_ctrl
  import cone_bist_pkg::*;
#(
  parameter int          VEC_W    = 22,
  parameter int          PATTERNS = 256,
  parameter logic [23:0] SEED     = 24'h00_0001,
  parameter int          SIG_W    = SIG_W_DEF
) (
  input  logic             CK,
  input  logic             RST,
  input  logic             start,
  input  logic [SIG_W-1:0] golden_sig,
  input  logic             resp_in,
  output logic [VEC_W-1:0] vec_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [SIG_W-1:0] signature
);

  // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
  localparam logic [23:0] SEED_EFF = (SEED == 24'd0) ? 24'd1 : SEED;
  localparam logic [15:0] CNT_LAST = 16'(PATTERNS - 1);

  state_t      state;
  logic [23:0] lfsr;
  logic [15:0] cnt;
  logic        accept;
  logic        run_en;

  assign accept  = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign run_en  = (state == ST_RUN);
  assign vec_out = lfsr[VEC_W-1:0];

  cone_bist_misr #(
    .SIG_W (SIG_W),
    .POLY  (SIG_W'(MISR_POLY))
  ) u_misr (
    .CK      (CK),
    .RST     (RST),
    .en      (run_en),
    .clr     (accept),
    .resp_in (resp_in),
    .sig     (signature)
  );

  // NOTE: every register, LFSR included, has an explicit reset value so an
  // aborted run leaves no partial state behind.
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state <= ST_IDLE;
      lfsr  <= SEED_EFF;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      pass  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state <= ST_RUN;
            lfsr  <= SEED_EFF;
            cnt   <= '0;
            busy  <= 1'b1;
            done  <= 1'b0;
            pass  <= 1'b0;
          end
        end
        ST_RUN: begin
          lfsr <= lfsr_next(lfsr);
          cnt  <= cnt + 16'd1;
          if (cnt == CNT_LAST) begin
            state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          state <= ST_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
          pass  <= (signature == golden_sig);
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
